// File: rtl/prog_loader_pkg.sv
// prog_loader shared definitions: FSM state encoding and default load address.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package prog_loader_pkg;

  // Default address of the first program byte.
  localparam logic [7:0] DEF_BASE_ADDR = 8'h00;

  // CHECK and ERROR are only reachable in the checksum build.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

endpackage

// File: rtl/prog_loader_cksum.sv
// loader_cksum: 8-bit modular accumulator used to validate a loaded image.
// Latency: sum reflects an add one cycle after add_en.
// Backpressure: none; the caller qualifies add_en with its own handshake.
module loader_cksum #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         add_en,
  input  logic [W-1:0] add_data,
  output logic [W-1:0] sum
);

  // Clear may coincide with the first add, so clear restarts the sum at add_data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum <= '0;
    end else if (clear) begin
      sum <= add_en ? add_data : '0;
    end else if (add_en) begin
      sum <= sum + add_data;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams a length-prefixed program image into memory, then releases the CPU.
// Latency: each accepted data byte is written in the following cycle; done rises the cycle after the last write.
// Backpressure: registered in_ready, high only while a byte can be consumed; optional checksum via PROG_LOADER_CKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int               ADDR_W    = 8,
  parameter int               DATA_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  state_t            state;
  logic [DATA_W-1:0] counter;
  logic [ADDR_W-1:0] addr_ptr;
  logic              accept;
  logic              last_byte;

  assign accept    = in_valid & in_ready;
  assign last_byte = (counter == DATA_W'(1));

`ifdef PROG_LOADER_CKSUM_EN
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] sum_next;
  logic              error_r;

  // Length, data and checksum bytes all pass through the same handshake.
  loader_cksum #(.W(DATA_W)) u_cksum (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept && (state == IDLE)),
    .add_en   (accept),
    .add_data (in_data),
    .sum      (sum)
  );

  assign sum_next = sum + in_data;
  assign error    = error_r;
`else
  assign error = 1'b0;
`endif

  // Loader FSM with registered handshake, memory-write and CPU-control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= BASE_ADDR;
      mem_data <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      counter  <= '0;
      addr_ptr <= BASE_ADDR;
`ifdef PROG_LOADER_CKSUM_EN
      error_r  <= 1'b0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            counter  <= in_data;
            addr_ptr <= BASE_ADDR;
            if (in_data == '0) begin
`ifdef PROG_LOADER_CKSUM_EN
              state <= CHECK;
`else
              state    <= DONE;
              in_ready <= 1'b0;
`endif
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            mem_we   <= 1'b1;
            mem_addr <= addr_ptr;
            mem_data <= in_data;
            addr_ptr <= addr_ptr + ADDR_W'(1);
            counter  <= counter - DATA_W'(1);
            if (last_byte) begin
`ifdef PROG_LOADER_CKSUM_EN
              state <= CHECK;
`else
              state    <= DONE;
              in_ready <= 1'b0;
`endif
            end
          end
        end
`ifdef PROG_LOADER_CKSUM_EN
        CHECK: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (sum_next == '0) begin
              state <= DONE;
            end else begin
              state   <= ERROR;
              error_r <= 1'b1;
            end
          end
        end
        ERROR: begin
          cpu_hold <= 1'b1;
          if (reload) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            error_r  <= 1'b0;
          end
        end
`endif
        DONE: begin
          // Release is delayed one cycle past entry so the trailing write lands first.
          if (reload) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
          end else begin
            in_ready <= 1'b0;
            cpu_hold <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
